gate_bist_controller: RTL and testbench

- Parametrised built-in self-test controller for the combinational gate models in the gate library.
- Drives the DUT input bus from a Galois LFSR for a programmable number of patterns.
- Compacts the DUT outputs into a Galois MISR signature and compares it against an expected signature.
- Sits beside any gate model; IN_W and OUT_W are set to match that model's input and output counts.

---
 rtl/gate_bist_if.sv | 31 +++
 rtl/gate_bist_controller.sv | 111 +++++++++++
 tb/tb_gate_bist_controller.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_if.sv
// Bus between the BIST controller and its host / gate model.
// The controller attaches as slave; the host that drives the run controls
// and the gate response attaches as master.
interface gate_bist_if #(
  parameter int unsigned IN_W  = 15,
  parameter int unsigned OUT_W = 10,
  parameter int unsigned PAT_W = 16
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] num_pat;
  logic [IN_W-1:0]  seed;
  logic [OUT_W-1:0] exp_sig;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;
  logic [PAT_W-1:0] pat_cnt;

  modport master (
    output start, abort, num_pat, seed, exp_sig, dut_out,
    input  dut_in, busy, done, pass, signature, pat_cnt
  );

  modport slave (
    input  start, abort, num_pat, seed, exp_sig, dut_out,
    output dut_in, busy, done, pass, signature, pat_cnt
  );
endinterface

// File: rtl/gate_bist_controller.sv
// BIST controller: Galois LFSR pattern source, Galois MISR response
// compactor, pattern counter and pass/fail compare against an expected
// signature.
module gate_bist_controller #(
  parameter int unsigned      IN_W      = 15,
  parameter int unsigned      OUT_W     = 10,
  parameter int unsigned      PAT_W     = 16,
  parameter logic [IN_W-1:0]  LFSR_TAPS = 15'h4001,
  parameter logic [OUT_W-1:0] MISR_TAPS = 10'h081
) (
  input  logic        clk,
  input  logic        rst,
  gate_bist_if.slave  bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t           r_state;
  logic [IN_W-1:0]  r_lfsr;
  logic [OUT_W-1:0] r_misr;
  logic [PAT_W-1:0] r_cnt;
  logic [PAT_W-1:0] r_num;
  logic [OUT_W-1:0] r_exp;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [IN_W-1:0]  w_lfsr_next;
  logic [OUT_W-1:0] w_misr_next;
  logic [IN_W-1:0]  w_seed;
  logic             w_last;

  // Next LFSR / MISR values, lock-up-safe seed, and last-pattern detect.
  always_comb begin
    w_lfsr_next = {r_lfsr[IN_W-2:0], 1'b0} ^ (r_lfsr[IN_W-1] ? LFSR_TAPS : '0);
    w_misr_next = {r_misr[OUT_W-2:0], 1'b0} ^ (r_misr[OUT_W-1] ? MISR_TAPS : '0)
                  ^ bus.dut_out;
    w_seed      = (bus.seed == '0) ? IN_W'(1) : bus.seed;
    w_last      = (r_cnt == (r_num - PAT_W'(1)));
  end

  // Run control FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= '0;
      r_misr  <= '0;
      r_cnt   <= '0;
      r_num   <= '0;
      r_exp   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_misr <= '0;
            r_cnt  <= '0;
            if (bus.num_pat != '0) begin
              r_num   <= bus.num_pat;
              r_exp   <= bus.exp_sig;
              r_lfsr  <= w_seed;
              r_pass  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end else begin
              // Empty run completes immediately against a zero signature.
              r_done <= 1'b1;
              r_pass <= (bus.exp_sig == '0);
            end
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            // Partial signature and count are left visible for debug.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_misr <= w_misr_next;
            r_lfsr <= w_lfsr_next;
            r_cnt  <= r_cnt + PAT_W'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_misr_next == r_exp);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_in    = r_lfsr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.signature = r_misr;
  assign bus.pat_cnt   = r_cnt;

endmodule

// File: tb/tb_gate_bist_controller.sv
// Self-checking bench for gate_bist_controller: transaction-level model
// compared every cycle, plus directed literal checks.
module tb_gate_bist_controller;

  localparam int unsigned IN_W  = 15;
  localparam int unsigned OUT_W = 10;
  localparam int unsigned PAT_W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gate_bist_if #(.IN_W(IN_W), .OUT_W(OUT_W), .PAT_W(PAT_W)) bif ();

  gate_bist_controller #(
    .IN_W(IN_W), .OUT_W(OUT_W), .PAT_W(PAT_W),
    .LFSR_TAPS(15'h4001), .MISR_TAPS(10'h081)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Stand-in gate model: constant response or a nonlinear hash of dut_in.
  bit               g_mode  = 1'b0;
  logic [OUT_W-1:0] g_const = '0;

  function automatic logic [OUT_W-1:0] gate_fn(input logic [IN_W-1:0] x);
    return x[9:0] ^ {x[14:10], x[14:10]} ^ (x[13:4] & x[10:1]);
  endfunction

  assign bif.dut_out = g_mode ? gate_fn(bif.dut_in) : g_const;

  // Polynomial view: multiply by x modulo x^15+x^14+1.
  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] x);
    logic [IN_W:0] t;
    t = {x, 1'b0};
    if (t[IN_W]) t = t ^ {1'b1, 15'h4001};
    return t[IN_W-1:0];
  endfunction

  // Multiply by x modulo x^10+x^7+1, then add the response word.
  function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] s,
                                                 input logic [OUT_W-1:0] d);
    logic [OUT_W:0] t;
    t = {s, 1'b0};
    if (t[OUT_W]) t = t ^ {1'b1, 10'h081};
    return t[OUT_W-1:0] ^ d;
  endfunction

  function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] x);
    return g_mode ? gate_fn(x) : g_const;
  endfunction

  // Whole-run signature for a seed and pattern count.
  function automatic logic [OUT_W-1:0] run_sig(input logic [IN_W-1:0] s, input int n);
    logic [IN_W-1:0]  p;
    logic [OUT_W-1:0] m;
    p = (s == '0) ? IN_W'(1) : s;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m = misr_step(m, resp(p));
      p = lfsr_step(p);
    end
    return m;
  endfunction

  // Transaction-level reference state.
  bit               m_run  = 1'b0;
  int               m_tgt  = 0;
  int               m_cnt  = 0;
  logic [IN_W-1:0]  m_pat  = '0;
  logic [OUT_W-1:0] m_sig  = '0;
  logic [OUT_W-1:0] m_exp  = '0;
  bit               m_done = 1'b0;
  bit               m_pass = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b0; m_tgt = 0; m_cnt = 0; m_pat = '0; m_sig = '0;
      m_exp = '0; m_done = 1'b0; m_pass = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_run) begin
        if (bif.start) begin
          m_sig = '0;
          m_cnt = 0;
          if (bif.num_pat == '0) begin
            m_done = 1'b1;
            m_pass = (bif.exp_sig == '0);
          end else begin
            m_run  = 1'b1;
            m_tgt  = int'(bif.num_pat);
            m_exp  = bif.exp_sig;
            m_pat  = (bif.seed == '0) ? IN_W'(1) : bif.seed;
            m_pass = 1'b0;
          end
        end
      end else if (bif.abort) begin
        m_run  = 1'b0;
        m_pass = 1'b0;
      end else begin
        m_sig = misr_step(m_sig, resp(m_pat));
        m_pat = lfsr_step(m_pat);
        m_cnt = m_cnt + 1;
        if (m_cnt == m_tgt) begin
          m_run  = 1'b0;
          m_done = 1'b1;
          m_pass = (m_sig == m_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy",  32'(bif.busy),      32'(m_run));
      chk("m_done",  32'(bif.done),      32'(m_done));
      chk("m_pass",  32'(bif.pass),      32'(m_pass));
      chk("m_sig",   32'(bif.signature), 32'(m_sig));
      chk("m_cnt",   32'(bif.pat_cnt),   32'(m_cnt));
      chk("m_dutin", 32'(bif.dut_in),    32'(m_pat));
    end
  end

  task automatic do_start(input int n, input logic [IN_W-1:0] s, input logic [OUT_W-1:0] e);
    @(negedge clk);
    bif.start   = 1'b1;
    bif.num_pat = PAT_W'(n);
    bif.seed    = s;
    bif.exp_sig = e;
    @(negedge clk);
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    k = 0;
    while (!bif.done && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (!bif.done) chk("done_timeout", 32'(k), 32'(0));
  endtask

  task automatic wait_idle(input int limit);
    int k;
    k = 0;
    while (bif.busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (bif.busy) chk("idle_timeout", 32'(k), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ret;
    int idx;
    rst         = 1'b1;
    bif.start   = 1'b0;
    bif.abort   = 1'b0;
    bif.num_pat = '0;
    bif.seed    = '0;
    bif.exp_sig = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy",  32'(bif.busy),      32'(0));
    chk("rst_dutin", 32'(bif.dut_in),    32'(0));
    chk("rst_sig",   32'(bif.signature), 32'(0));
    chk("rst_cnt",   32'(bif.pat_cnt),   32'(0));
    chk("rst_done",  32'(bif.done),      32'(0));
    rst = 1'b0;

    // Reset mid-run, asserted in the 3rd RUN cycle.
    g_mode = 1'b1;
    do_start(5, 15'h1234, 10'h155);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy",  32'(bif.busy),      32'(0));
    chk("mid_rst_dutin", 32'(bif.dut_in),    32'(0));
    chk("mid_rst_sig",   32'(bif.signature), 32'(0));
    chk("mid_rst_cnt",   32'(bif.pat_cnt),   32'(0));
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_nodone", 32'(bif.done), 32'(0));
    end

    // Single pattern.
    g_mode  = 1'b0;
    g_const = 10'h3FF;
    do_start(1, 15'h0001, 10'h3FF);
    chk("single_dutin", 32'(bif.dut_in), 32'h0001);
    @(negedge clk);
    chk("single_done", 32'(bif.done),      32'(1));
    chk("single_sig",  32'(bif.signature), 32'h3FF);
    chk("single_pass", 32'(bif.pass),      32'(1));
    chk("single_cnt",  32'(bif.pat_cnt),   32'(1));
    @(negedge clk);
    chk("single_pulse", 32'(bif.done), 32'(0));

    // Two patterns, matching and mismatching expected signature.
    do_start(2, 15'h0001, 10'h080);
    chk("two_dutin0", 32'(bif.dut_in), 32'h0001);
    @(negedge clk);
    chk("two_dutin1", 32'(bif.dut_in), 32'h0002);
    @(negedge clk);
    chk("two_done", 32'(bif.done),      32'(1));
    chk("two_sig",  32'(bif.signature), 32'h080);
    chk("two_pass", 32'(bif.pass),      32'(1));
    do_start(2, 15'h0001, 10'h081);
    repeat (2) @(negedge clk);
    chk("two_bad_sig",  32'(bif.signature), 32'h080);
    chk("two_bad_pass", 32'(bif.pass),      32'(0));

    // Zero seed falls back to 1.
    do_start(3, 15'h0000, 10'h000);
    chk("zseed0", 32'(bif.dut_in), 32'h0001);
    @(negedge clk);
    chk("zseed1", 32'(bif.dut_in), 32'h0002);
    @(negedge clk);
    chk("zseed2", 32'(bif.dut_in), 32'h0004);
    wait_done(10);

    // Zero count completes immediately without going busy.
    do_start(0, 15'h7ABC, 10'h000);
    chk("zcnt_done", 32'(bif.done), 32'(1));
    chk("zcnt_pass", 32'(bif.pass), 32'(1));
    chk("zcnt_busy", 32'(bif.busy), 32'(0));
    @(negedge clk);
    chk("zcnt_pulse", 32'(bif.done), 32'(0));

    // Abort in 4th RUN cycle, with an ignored start in between.
    g_mode = 1'b1;
    do_start(8, 15'h0F0F, 10'h000);
    @(negedge clk);
    bif.start   = 1'b1;
    bif.num_pat = PAT_W'(2);
    @(negedge clk);
    bif.start = 1'b0;
    @(negedge clk);
    bif.abort = 1'b1;
    @(negedge clk);
    bif.abort = 1'b0;
    chk("abort_busy", 32'(bif.busy),    32'(0));
    chk("abort_done", 32'(bif.done),    32'(0));
    chk("abort_pass", 32'(bif.pass),    32'(0));
    chk("abort_cnt",  32'(bif.pat_cnt), 32'(3));
    // Abort in IDLE is harmless.
    bif.abort = 1'b1;
    @(negedge clk);
    bif.abort = 1'b0;
    chk("idle_abort_cnt", 32'(bif.pat_cnt), 32'(3));

    // Full LFSR period, then back-to-back start.
    g_mode  = 1'b0;
    g_const = '0;
    do_start(32767, 15'h0001, 10'h000);
    first_ret = 0;
    idx = 1;
    while (idx <= 40000) begin
      if (idx > 1 && bif.dut_in == 15'h0001 && first_ret == 0) first_ret = idx;
      if (bif.done) break;
      @(negedge clk);
      idx++;
    end
    if (!bif.done) chk("period_timeout", 32'(idx), 32'(0));
    chk("period_ret",  32'(first_ret),     32'(32768));
    chk("period_sig",  32'(bif.signature), 32'(0));
    chk("period_pass", 32'(bif.pass),      32'(1));
    chk("period_cnt",  32'(bif.pat_cnt),   32'(32767));
    bif.start   = 1'b1;
    bif.num_pat = PAT_W'(3);
    bif.seed    = 15'h0005;
    bif.exp_sig = 10'h000;
    @(negedge clk);
    bif.start = 1'b0;
    chk("b2b_busy",  32'(bif.busy),   32'(1));
    chk("b2b_dutin", 32'(bif.dut_in), 32'h0005);
    wait_done(10);

    // Randomized runs against the model.
    g_mode = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int n;
      logic [IN_W-1:0]  s;
      logic [OUT_W-1:0] e;
      n = int'($urandom_range(0, 20));
      s = ($urandom_range(0, 5) == 0) ? '0 : IN_W'($urandom);
      e = ($urandom_range(0, 1) == 0) ? run_sig(s, n) : OUT_W'($urandom);
      do_start(n, s, e);
      for (int c = 0; c < n + 2; c++) begin
        @(negedge clk);
        bif.abort   = ($urandom_range(0, 39) == 0);
        bif.start   = ($urandom_range(0, 7) == 0);
        bif.num_pat = PAT_W'($urandom_range(0, 6));
        bif.seed    = IN_W'($urandom);
        bif.exp_sig = OUT_W'($urandom);
        rst         = ($urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      bif.abort = 1'b0;
      bif.start = 1'b0;
      rst       = 1'b0;
      wait_idle(100);
      @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
